spart_rx: RTL and testbench
===========================

SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-002 Port clk, input, 1: system clock; every register SHALL be clocked on its rising edge.
REQ-003 Port rst, input, 1: asynchronous active-high reset.
REQ-004 Port baud_en, input, 1: one-cycle pulse at 16x the baud rate, from the baud generator; all bit timing SHALL count only these pulses.
REQ-005 Port rxd, input, 1: asynchronous serial line, idles high.
REQ-006 Port rd_ack, input, 1: one-cycle pulse when the bus interface reads the receive buffer.
REQ-007 Port rx_data, output, 8: last received byte.
REQ-008 Port rda, output, 1: receive data available.
REQ-009 Port frame_err, output, 1: the stop bit of the last loaded byte sampled low.
REQ-010 Port overrun, output, 1: a byte was loaded while rda was still set.

Function
REQ-011 rxd SHALL pass through a two-flop synchronizer; both flops reset to 1; all logic below SHALL use the synchronized value (rxs).
REQ-012 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-013 A 4-bit tick counter (tcnt) and a 3-bit bit index (bidx) SHALL advance only on cycles where baud_en=1.
REQ-014 IDLE: on baud_en=1 with rxs=0, the FSM SHALL go to START with tcnt=0.
REQ-015 START: on the baud_en tick where tcnt=7, the block SHALL sample rxs (mid start bit).
- If rxs=1 (false start), the FSM SHALL return to IDLE.
- If rxs=0, the FSM SHALL go to DATA with tcnt=0 and bidx=0.
REQ-016 DATA: on each baud_en tick where tcnt=15, the block SHALL shift rxs into an 8-bit shift register, LSB first (bit bidx = rxs).
- When bidx=7, the FSM SHALL go to STOP; otherwise it SHALL increment bidx.
- tcnt SHALL wrap 15->0.
REQ-017 STOP: on the baud_en tick where tcnt=15, the block SHALL sample the stop bit and, in that same cycle, load the byte:
- rx_data <= shift register;
- rda <= 1;
- frame_err <= ~rxs.
The FSM SHALL then return to IDLE.
REQ-018 A load SHALL set overrun=1 if rda was already 1 and rd_ack=0 in the load cycle; rx_data SHALL be overwritten with the new byte.
REQ-019 rd_ack=1 with no load in the same cycle SHALL clear rda and overrun.
- rx_data SHALL hold its value.
- frame_err SHALL hold until the next load.
REQ-020 rd_ack=1 and a load in the same cycle: the load SHALL win; rda stays 1 and overrun SHALL be set to 0.
REQ-021 rd_ack while rda=0 SHALL have no effect.
REQ-022 Latency: rda SHALL rise on the clock edge of the STOP-state tcnt=15 tick, i.e. 8+16*9 = 152 baud_en ticks after the tick that detected rxs=0 in IDLE.
REQ-023 Cycles with baud_en=0 SHALL leave the FSM, tcnt and bidx unchanged.
REQ-024 Back-to-back frames: a start bit immediately following a stop bit SHALL be detected from IDLE on the next baud_en tick.

Reset
REQ-025 rst=1 SHALL immediately force the following, regardless of mid-frame state:
- state=IDLE;
- tcnt=0 and bidx=0;
- shift register=0x00;
- rx_data=0x00;
- rda=0, frame_err=0, overrun=0;
- synchronizer flops=1.
REQ-026 After rst is released, the block SHALL ignore any frame in progress and wait in IDLE for the next falling edge on rxs.

Verification
REQ-027 With baud_en tied high, send 0xA6 at 16 clk/bit with a high stop bit -> rda=1, rx_data=0xA6, frame_err=0, overrun=0; then pulse rd_ack -> rda=0 and rx_data=0xA6 still.
REQ-028 Send 0x59 with the stop bit driven low -> rda=1, rx_data=0x59, frame_err=1.
REQ-029 Pulse rxd low for 4 baud_en ticks, then high -> no rda; FSM returns to IDLE; a following 0x3C frame is received correctly.
REQ-030 Send two frames, 0x11 then 0x22, with no rd_ack -> overrun=1 and rx_data=0x22; then rd_ack -> rda=0 and overrun=0.
REQ-031 Assert rd_ack in exactly the cycle the second byte loads -> rda=1, overrun=0, rx_data equals the second byte.
REQ-032 Assert rst during DATA bit 3 -> all outputs=0 immediately; after release, a 0xF0 frame is received cleanly with baud_en=1 every 4th clk.

Source files
------------

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deserializer with a one-byte receive buffer
// and data-available, framing-error and overrun status.
module spart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_en,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TCNT_W = 4;
    localparam int unsigned BIDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [TCNT_W-1:0]   tcnt_q,      tcnt_d;
    logic [BIDX_W-1:0]   bidx_q,      bidx_d;
    logic [DATA_W-1:0]   shreg_q,     shreg_d;
    logic [DATA_W-1:0]   rx_data_q,   rx_data_d;
    logic                rda_q,       rda_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q,   overrun_d;
    logic                rx_meta_q,   rx_meta_d;
    logic                rxs_q,       rxs_d;
    logic                load_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bidx_q      <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bidx_q      <= bidx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rda_q       <= rda_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
        end
    end

    // Bit timing: everything advances only on baud_en ticks.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bidx_d    = bidx_q;
        shreg_d   = shreg_q;
        load_c    = 1'b0;
        rx_meta_d = rxd;
        rxs_d     = rx_meta_q;

        if (baud_en) begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end
                end
                START: begin
                    if (tcnt_q == TCNT_W'(7)) begin
                        if (rxs_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tcnt_d  = '0;
                            bidx_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
                DATA: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (tcnt_q == TCNT_W'(15)) begin
                        shreg_d[bidx_q] = rxs_q;
                        if (bidx_q == BIDX_W'(7)) begin
                            state_d = STOP;
                        end else begin
                            bidx_d = bidx_q + BIDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (tcnt_q == TCNT_W'(15)) begin
                        load_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Receive buffer: a load always wins over a simultaneous read acknowledge.
    always_comb begin
        rx_data_d   = rx_data_q;
        rda_d       = rda_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (load_c) begin
            rx_data_d   = shreg_q;
            rda_d       = 1'b1;
            frame_err_d = ~rxs_q;
            overrun_d   = rda_q & ~rd_ack;
        end else if (rd_ack) begin
            rda_d     = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rda       = rda_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: frames are driven bit by bit, expected bytes are
// queued at stimulus time and a negedge monitor checks each buffer load.
module tb_spart_rx;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       baud_en;
    logic       rxd;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rda;
    logic       frame_err;
    logic       overrun;

    int   n_total;
    int   n_pass;
    int   div;
    int   bcnt;
    exp_t sb[$];

    spart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .baud_en   (baud_en),
        .rxd       (rxd),
        .rd_ack    (rd_ack),
        .rx_data   (rx_data),
        .rda       (rda),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // baud_en is high on one clock out of every div
    initial begin
        baud_en = 1'b0;
        bcnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bcnt >= div - 1) begin
                bcnt    = 0;
                baud_en = 1'b1;
            end else begin
                bcnt    = bcnt + 1;
                baud_en = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] d, input logic fe, input logic ov);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.ov   = ov;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (16 * div) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
    endtask

    // Monitor: a load is seen as rda rising or rx_data changing while rda is held.
    initial begin
        logic       prev_rda;
        logic [7:0] prev_data;
        exp_t       e;
        prev_rda  = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && rda && (!prev_rda || rx_data !== prev_data)) begin
                if (sb.size() == 0) begin
                    n_total = n_total + 1;
                    $display("FAIL unexpected_load: got rx_data=%02h expected no load", rx_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_rx_data",   32'(rx_data),   32'(e.data));
                    check("sb_frame_err", 32'(frame_err), 32'(e.fe));
                    check("sb_overrun",   32'(overrun),   32'(e.ov));
                end
            end
            prev_rda  = rst ? 1'b0 : rda;
            prev_data = rx_data;
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        div     = 1;
        rst     = 1'b1;
        rxd     = 1'b1;
        rd_ack  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'h0);
        check("reset_rda",       32'(rda),       32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun",   32'(overrun),   32'h0);
        rst = 1'b0;
        idle(10);

        // Clean frame, then read it out
        push(8'hA6, 1'b0, 1'b0);
        send_byte(8'hA6, 1'b1);
        idle(20);
        ack();
        @(negedge clk);
        check("a6_ack_rda",     32'(rda),     32'h0);
        check("a6_ack_rx_data", 32'(rx_data), 32'hA6);

        // Low stop bit; frame_err survives the read
        idle(20);
        push(8'h59, 1'b1, 1'b0);
        send_byte(8'h59, 1'b0);
        idle(40);
        ack();
        @(negedge clk);
        check("59_ack_rda",       32'(rda),       32'h0);
        check("59_ack_frame_err", 32'(frame_err), 32'h1);

        // Glitch shorter than half a bit is rejected
        idle(20);
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        @(negedge clk);
        check("glitch_rda", 32'(rda), 32'h0);
        idle(5);
        push(8'h3C, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1);
        idle(20);
        ack();

        // Two frames without a read
        idle(20);
        push(8'h11, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1);
        idle(20);
        push(8'h22, 1'b0, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(20);
        ack();
        @(negedge clk);
        check("ovr_ack_rda",     32'(rda),     32'h0);
        check("ovr_ack_overrun", 32'(overrun), 32'h0);
        check("ovr_rx_data",     32'(rx_data), 32'h22);

        // Read acknowledge in the exact load cycle: 2 sync + 1 detect + 152 ticks
        idle(20);
        push(8'h44, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1);
        idle(20);
        push(8'h88, 1'b0, 1'b0);
        fork
            send_byte(8'h88, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                rd_ack = 1'b1;
                @(posedge clk);
                #1;
                rd_ack = 1'b0;
            end
        join
        @(negedge clk);
        check("coinc_rda",     32'(rda),     32'h1);
        check("coinc_overrun", 32'(overrun), 32'h0);
        check("coinc_rx_data", 32'(rx_data), 32'h88);
        ack();

        // Reset in the middle of data bit 3; remaining bits of 0xF8 are all ones
        idle(20);
        fork
            send_byte(8'hF8, 1'b1);
            begin
                repeat (70) @(posedge clk);
                #1;
                rst = 1'b1;
                @(negedge clk);
                check("midrst_rx_data",   32'(rx_data),   32'h0);
                check("midrst_rda",       32'(rda),       32'h0);
                check("midrst_frame_err", 32'(frame_err), 32'h0);
                check("midrst_overrun",   32'(overrun),   32'h0);
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        idle(20);
        @(negedge clk);
        check("post_rst_rda", 32'(rda), 32'h0);

        div = 4;
        idle(20);
        push(8'hF0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b1);
        idle(40);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
